// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: source count, FSM encoding,
// one-hot cause codes and the fixed-priority source selector.
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int TAKEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACTIVE  = 2'd2
  } irq_state_e;

  localparam logic [NUM_IRQ-1:0] EXT1 = 4'b0001;
  localparam logic [NUM_IRQ-1:0] EXT2 = 4'b0010;
  localparam logic [NUM_IRQ-1:0] TIM1 = 4'b0100;
  localparam logic [NUM_IRQ-1:0] TIM2 = 4'b1000;

  // Highest bit wins; must match the controller's irq_target priority.
  function automatic logic [NUM_IRQ-1:0] irq_select(input logic [NUM_IRQ-1:0] pend);
    logic [NUM_IRQ-1:0] sel;
    sel = '0;
    if (pend[3])      sel = TIM2;
    else if (pend[2]) sel = TIM1;
    else if (pend[1]) sel = EXT2;
    else if (pend[0]) sel = EXT1;
    return sel;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-line synchronizer for an active-low IRQ source; resets to the
// inactive level so no spurious pending appears after reset.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/irq_dispatcher.sv
// Synchronizes four active-low IRQ lines, raises a single non-nesting request
// to the core, and tracks vector, return address, cause and accept count.
module irq_dispatcher
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_sources,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic [31:0]         irq_target,
  input  logic [31:0]         core_pc_next,
  input  logic                core_irq_ack,
  input  logic                core_mret,
  output logic                irq_req,
  output logic [31:0]         irq_vector,
  output logic [31:0]         irq_epc,
  output logic [NUM_IRQ-1:0]  irq_cause,
  output logic                irq_active,
  output logic [NUM_IRQ-1:0]  irq_pending,
  output logic [TAKEN_W-1:0]  irq_taken
);

  function automatic logic [TAKEN_W-1:0] sat_inc(input logic [TAKEN_W-1:0] v);
    return (v == '1) ? v : v + TAKEN_W'(1);
  endfunction

  irq_state_e          r_state;
  irq_state_e          w_state_nxt;
  logic [NUM_IRQ-1:0]  w_sync;
  logic [NUM_IRQ-1:0]  w_pending;
  logic                w_capture;
  logic                w_accept;
  logic                w_withdraw;
  logic                w_return;
  logic [31:0]         r_vector;
  logic [31:0]         r_epc;
  logic [NUM_IRQ-1:0]  r_cause;
  logic [TAKEN_W-1:0]  r_taken;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (irq_sources[g]),
      .o_q   (w_sync[g])
    );
  end

  // Lines are active-low: invert after synchronization, then gate by mask.
  assign w_pending = ~w_sync & irq_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_withdraw  = 1'b0;
    w_return    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pending) begin
          w_state_nxt = ST_REQUEST;
          w_capture   = 1'b1;
        end
      end
      ST_REQUEST: begin
        // Ack takes precedence over a source that drops in the same cycle.
        if (core_irq_ack) begin
          w_state_nxt = ST_ACTIVE;
          w_accept    = 1'b1;
        end else if ((w_pending & r_cause) == '0) begin
          w_state_nxt = ST_IDLE;
          w_withdraw  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (core_mret) begin
          w_state_nxt = ST_IDLE;
          w_return    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vector <= '0;
      r_epc    <= '0;
      r_cause  <= '0;
      r_taken  <= '0;
    end else begin
      if (w_capture) begin
        r_vector <= irq_target;
        r_cause  <= irq_select(w_pending);
      end
      if (w_accept) begin
        r_epc   <= core_pc_next;
        r_taken <= sat_inc(r_taken);
      end
      if (w_withdraw || w_return) begin
        r_cause <= '0;
      end
    end
  end

  assign irq_req     = (r_state == ST_REQUEST);
  assign irq_active  = (r_state == ST_ACTIVE);
  assign irq_vector  = r_vector;
  assign irq_epc     = r_epc;
  assign irq_cause   = r_cause;
  assign irq_pending = w_pending;
  assign irq_taken   = r_taken;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Scoreboard bench for irq_dispatcher: stimulus queues expected request and
// accept responses, a monitor compares them when irq_req / irq_active rise.
module tb_irq_dispatcher;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] taken;
    logic [3:0]  cause;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_sources;
  logic [3:0]  irq_mask;
  logic [31:0] irq_target;
  logic [31:0] core_pc_next;
  logic        core_irq_ack;
  logic        core_mret;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [31:0] irq_epc;
  logic [3:0]  irq_cause;
  logic        irq_active;
  logic [3:0]  irq_pending;
  logic [15:0] irq_taken;

  int checks = 0;
  int errors = 0;
  exp_t req_q[$];
  exp_t act_q[$];

  irq_dispatcher #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_sources  (irq_sources),
    .irq_mask     (irq_mask),
    .irq_target   (irq_target),
    .core_pc_next (core_pc_next),
    .core_irq_ack (core_irq_ack),
    .core_mret    (core_mret),
    .irq_req      (irq_req),
    .irq_vector   (irq_vector),
    .irq_epc      (irq_epc),
    .irq_cause    (irq_cause),
    .irq_active   (irq_active),
    .irq_pending  (irq_pending),
    .irq_taken    (irq_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare on rising irq_req and rising irq_active.
  initial begin
    logic prev_req;
    logic prev_act;
    exp_t e;
    prev_req = 1'b0;
    prev_act = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (irq_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'(irq_req), 32'd0);
        end else begin
          e = req_q.pop_front();
          chk("req_vector", irq_vector, e.addr);
          chk("req_cause", 32'(irq_cause), 32'(e.cause));
        end
      end
      if (irq_active && !prev_act) begin
        if (act_q.size() == 0) begin
          chk("act_unexpected", 32'(irq_active), 32'd0);
        end else begin
          e = act_q.pop_front();
          chk("act_epc", irq_epc, e.addr);
          chk("act_taken", 32'(irq_taken), 32'(e.taken));
          chk("act_cause", 32'(irq_cause), 32'(e.cause));
        end
      end
      prev_req = irq_req;
      prev_act = irq_active;
    end
  end

  task automatic wait_req();
    for (int k = 0; k < 20 && !irq_req; k++) @(negedge clk);
    if (!irq_req) chk("wait_req_timeout", 32'(irq_req), 32'd1);
  endtask

  // Full request/accept/return sequence on tim1 (bit2).
  task automatic do_cycle(input logic [31:0] pc, input logic [15:0] exp_taken,
                          input bit preload);
    req_q.push_back(exp_t'{addr: 32'h0000_0500, taken: 16'h0, cause: 4'b0100});
    irq_sources = 4'b1011;
    wait_req();
    if (preload) begin
      force dut.r_taken = 16'hFFFD;
      @(negedge clk);
      release dut.r_taken;
    end
    core_pc_next = pc;
    core_irq_ack = 1'b1;
    act_q.push_back(exp_t'{addr: pc, taken: exp_taken, cause: 4'b0100});
    @(negedge clk);
    core_irq_ack = 1'b0;
    irq_sources  = 4'b1111;
    repeat (3) @(negedge clk);
    core_mret = 1'b1;
    @(negedge clk);
    core_mret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    irq_sources  = 4'b1111;
    irq_mask     = 4'b1111;
    irq_target   = 32'h0;
    core_pc_next = 32'h0;
    core_irq_ack = 1'b0;
    core_mret    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_active", 32'(irq_active), 32'd0);
    chk("rst_cause", 32'(irq_cause), 32'd0);
    chk("rst_vector", irq_vector, 32'd0);
    chk("rst_epc", irq_epc, 32'd0);
    chk("rst_taken", 32'(irq_taken), 32'd0);
    chk("rst_pending", 32'(irq_pending), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic: ext1 request, latency, accept, return.
    irq_mask   = 4'b0001;
    irq_target = 32'h0000_0200;
    req_q.push_back(exp_t'{addr: 32'h0000_0200, taken: 16'h0, cause: 4'b0001});
    irq_sources = 4'b1110;
    @(posedge clk);
    @(posedge clk); #1;
    chk("lat_edge1", 32'(irq_req), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(irq_req), 32'd1);
    @(negedge clk);
    core_pc_next = 32'h0000_0084;
    core_irq_ack = 1'b1;
    act_q.push_back(exp_t'{addr: 32'h0000_0084, taken: 16'd1, cause: 4'b0001});
    @(negedge clk);
    core_irq_ack = 1'b0;
    chk("basic_req_off", 32'(irq_req), 32'd0);
    chk("basic_active", 32'(irq_active), 32'd1);
    core_pc_next = 32'h0000_0999;
    core_irq_ack = 1'b1;
    @(negedge clk);
    core_irq_ack = 1'b0;
    chk("ack_in_active_taken", 32'(irq_taken), 32'd1);
    chk("ack_in_active_epc", irq_epc, 32'h0000_0084);
    irq_sources = 4'b1111;
    repeat (3) @(negedge clk);
    core_mret = 1'b1;
    @(negedge clk);
    core_mret = 1'b0;
    chk("mret_active", 32'(irq_active), 32'd0);
    chk("mret_cause", 32'(irq_cause), 32'd0);
    chk("mret_epc_hold", irq_epc, 32'h0000_0084);
    chk("mret_vector_hold", irq_vector, 32'h0000_0200);
    core_mret = 1'b1;
    @(negedge clk);
    core_mret = 1'b0;
    chk("mret_in_idle", 32'(irq_req | irq_active), 32'd0);

    // Masking: all lines low, nothing enabled.
    irq_mask    = 4'b0000;
    irq_sources = 4'b0000;
    repeat (20) @(negedge clk);
    chk("mask_req", 32'(irq_req), 32'd0);
    chk("mask_pending", 32'(irq_pending), 32'd0);
    irq_sources = 4'b1111;
    repeat (3) @(negedge clk);

    // Priority: tim2 and ext1 together, tim2 wins; ext1 follows after mret.
    irq_mask   = 4'b1111;
    irq_target = 32'h0000_0400;
    req_q.push_back(exp_t'{addr: 32'h0000_0400, taken: 16'h0, cause: 4'b1000});
    irq_sources = 4'b0110;
    wait_req();
    irq_target = 32'h0000_0999;
    @(negedge clk);
    chk("req_vector_stable", irq_vector, 32'h0000_0400);
    chk("req_cause_stable", 32'(irq_cause), 32'b1000);
    core_pc_next = 32'h0000_1234;
    core_irq_ack = 1'b1;
    act_q.push_back(exp_t'{addr: 32'h0000_1234, taken: 16'd2, cause: 4'b1000});
    @(negedge clk);
    core_irq_ack = 1'b0;
    irq_sources  = 4'b1110;
    repeat (3) @(negedge clk);
    chk("no_nesting", 32'(irq_req), 32'd0);
    irq_target = 32'h0000_0100;
    req_q.push_back(exp_t'{addr: 32'h0000_0100, taken: 16'h0, cause: 4'b0001});
    core_mret = 1'b1;
    @(posedge clk); #1;
    core_mret = 1'b0;
    chk("rereq_not_same_edge", 32'(irq_req), 32'd0);
    @(posedge clk); #1;
    chk("rereq_next_edge", 32'(irq_req), 32'd1);

    // Withdraw: ext1 released while requesting, no ack.
    @(negedge clk);
    irq_sources = 4'b1111;
    repeat (2) @(posedge clk); #1;
    chk("wd_still_req", 32'(irq_req), 32'd1);
    chk("wd_pending_low", 32'(irq_pending), 32'd0);
    @(posedge clk); #1;
    chk("wd_req", 32'(irq_req), 32'd0);
    chk("wd_active", 32'(irq_active), 32'd0);

    // Ack in the same cycle the pending bit drops: ack wins.
    @(negedge clk);
    irq_target = 32'h0000_0300;
    req_q.push_back(exp_t'{addr: 32'h0000_0300, taken: 16'h0, cause: 4'b0001});
    irq_sources = 4'b1110;
    wait_req();
    irq_sources = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ackwin_pending_low", 32'(irq_pending), 32'd0);
    core_pc_next = 32'h0000_0088;
    core_irq_ack = 1'b1;
    act_q.push_back(exp_t'{addr: 32'h0000_0088, taken: 16'd3, cause: 4'b0001});
    @(negedge clk);
    core_irq_ack = 1'b0;
    chk("ackwin_active", 32'(irq_active), 32'd1);

    // Asynchronous reset during ACTIVE.
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_req", 32'(irq_req), 32'd0);
    chk("mrst_active", 32'(irq_active), 32'd0);
    chk("mrst_cause", 32'(irq_cause), 32'd0);
    chk("mrst_vector", irq_vector, 32'd0);
    chk("mrst_epc", irq_epc, 32'd0);
    chk("mrst_taken", 32'(irq_taken), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_after_req", 32'(irq_req), 32'd0);
    chk("mrst_after_active", 32'(irq_active), 32'd0);

    // Saturation: count a few accepts, preload near the top, then run past it.
    irq_mask   = 4'b0100;
    irq_target = 32'h0000_0500;
    for (int i = 1; i <= 5; i++) do_cycle(32'h0000_1000 + 32'(i), 16'(i), 1'b0);
    chk("sat_count5", 32'(irq_taken), 32'd5);
    do_cycle(32'h0000_2000, 16'hFFFE, 1'b1);
    do_cycle(32'h0000_2004, 16'hFFFF, 1'b0);
    do_cycle(32'h0000_2008, 16'hFFFF, 1'b0);
    do_cycle(32'h0000_200C, 16'hFFFF, 1'b0);
    repeat (4) @(negedge clk);
    chk("sat_hold", 32'(irq_taken), 32'h0000_FFFF);
    chk("sat_idle", 32'(irq_req | irq_active), 32'd0);

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("act_q_empty", 32'(act_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_dispatcher.md
IRQ_DISPATCHER -- requirements
Module: irq_dispatcher

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of synchronizer flops per IRQ source line (minimum 2).
REQ-002 SHALL have ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- irq_sources  input  4  raw IRQ lines, active-low, level; bit0 ext1, bit1 ext2, bit2 tim1, bit3 tim2.
- irq_mask  input  4  per-source enable from the interrupt controller; 1 = enabled.
- irq_target  input  32  ISR flash address from the interrupt controller.
- core_pc_next  input  32  resume address offered by the core.
- core_irq_ack  input  1  core accepts the request at an instruction boundary.
- core_mret  input  1  core executes return-from-interrupt.
- irq_req  output  1  interrupt request to the core.
- irq_vector  output  32  latched ISR address for the core PC redirect.
- irq_epc  output  32  saved return address.
- irq_cause  output  4  one-hot source being requested or serviced.
- irq_active  output  1  high while the core is inside an ISR.
- irq_pending  output  4  synchronized, masked, active-high source levels.
- irq_taken  output  16  count of accepted interrupts.

Function
REQ-003 SHALL pass each irq_sources bit through SYNC_STAGES flops, then invert it and AND it with irq_mask to form irq_pending.
REQ-004 SHALL select the pending source by fixed priority: bit3 highest, bit0 lowest, matching the controller's irq_target priority.
REQ-005 SHALL implement the FSM states IDLE, REQUEST and ACTIVE.
REQ-006 IDLE -> REQUEST SHALL occur on the first rising edge at which irq_pending != 0; on that edge the block SHALL capture irq_vector <= irq_target and set irq_cause to the one-hot selected source.
REQ-007 irq_req SHALL be 1 exactly while the FSM is in REQUEST.
REQ-008 Latency: when a source line falls before edge N and stays low, irq_req SHALL be 1 after edge N+SYNC_STAGES.
REQ-009 In REQUEST with core_irq_ack=1, the FSM SHALL go to ACTIVE, capture irq_epc <= core_pc_next, and increment irq_taken; irq_taken SHALL saturate at 16'hFFFF.
REQ-010 In REQUEST, if the captured source's irq_pending bit is 0 and core_irq_ack=0, the FSM SHALL withdraw to IDLE; if ack arrives in the same cycle, ack SHALL win.
REQ-011 While in REQUEST, irq_vector and irq_cause SHALL stay stable; a higher-priority source arriving during REQUEST SHALL NOT preempt the request.
REQ-012 irq_active SHALL be 1 exactly while the FSM is in ACTIVE.
REQ-013 No nesting: in ACTIVE, new pending sources SHALL be ignored.
REQ-014 ACTIVE -> IDLE SHALL occur on core_mret=1, and irq_cause SHALL clear to 0.
REQ-015 irq_epc and irq_vector SHALL hold their values after mret until the next capture.
REQ-016 core_mret outside ACTIVE and core_irq_ack outside REQUEST SHALL be ignored.
REQ-017 After mret, a source still pending SHALL re-enter REQUEST no earlier than the edge following the return to IDLE.

Reset
REQ-018 reset=0 SHALL asynchronously force FSM=IDLE, irq_req=0, irq_active=0, irq_cause=0, irq_vector=0, irq_epc=0 and irq_taken=0.
REQ-019 reset=0 SHALL load all synchronizer flops with 1 (inactive), so irq_pending=0.
REQ-020 Reset asserted during REQUEST or ACTIVE SHALL abort the operation with no residual request after release.

Structure
REQ-021 Shared package irq_pkg SHALL hold NUM_IRQ=4, the FSM state enumeration, the one-hot cause constants (EXT1, EXT2, TIM1, TIM2) and the irq_taken width.
REQ-022 The synchronizer SHALL be the sub-module irq_sync (one line, SYNC_STAGES deep, asynchronous reset to 1), instantiated 4 times.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- Basic: mask=4'b0001, irq_target=32'h0000_0200, drive bit0 low at edge 10 -> irq_req=1 after edge 12, irq_vector=32'h200, irq_cause=4'b0001; ack with pc_next=32'h0000_0084 -> irq_active=1, irq_epc=32'h84, irq_taken=1.
- Masking: mask=4'b0000, all sources low for 20 cycles -> irq_req stays 0 and irq_pending=0.
- Priority: bits 0 and 3 low simultaneously, mask=4'hF, irq_target=32'h0000_0400 -> irq_cause=4'b1000, irq_vector=32'h400; after mret with bit3 released, re-request with irq_cause=4'b0001.
- Withdraw vs ack: release source so its pending bit drops in REQUEST with no ack -> IDLE and irq_req=0; repeat with ack in that same cycle -> ACTIVE.
- Mid-operation reset: pulse reset=0 during ACTIVE -> all outputs 0 immediately; after release with sources high, irq_req stays 0.
- Saturation: force 65536 accept/mret cycles -> irq_taken=16'hFFFF and it holds.
